text_render_scheduler: RTL and testbench

Sequences full-frame text rendering for the virtual console. On a start pulse it walks the character grid row-major, fetches each cell's character and colour indices, and requests glyph rows from the font shape lookup. It writes one colour-index pixel per accepted transfer into the SRAM frame buffer. It also owns cursor visibility (blink timing) and applies the cursor overlay by swapping foreground and background colours.

---
 rtl/text_render_scheduler.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_text_render_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_render_scheduler.sv
// text_render_scheduler
//
// Renders one full frame of the text console into the SRAM frame buffer.
// On start the character grid is walked row-major. For every cell the
// character and colour indices are fetched, then each glyph row is requested
// from the font lookup and expanded into WIDTH_PER_CHARACTER colour-index
// pixel writes. The block also keeps the cursor blink timing and draws the
// cursor by swapping foreground and background of the cursor cell.
//
// Handshakes:
//   font_req/font_ack : font_req rises in FONT and holds font_char/font_row
//                       stable until a cycle with font_ack=1. font_bits is
//                       taken in that same cycle.
//   sram_we/sram_ready: a pixel transfers on a rising clock edge where both
//                       sram_we and sram_ready are 1. sram_addr/sram_data
//                       do not change while sram_we=1 and sram_ready=0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a frame (ignored unless idle)
//   cursor_position     [15:8] cursor row, [7:0] cursor column
//   cursor_mode         0 blink, 1 off, 2 on, 3 off
//   cell_addr           linear cell index; cell_char/fg/bg valid one cycle later
//   cell_char/fg/bg     cell contents
//   font_req/char/row   glyph row request
//   font_ack/font_bits  glyph row response, MSB = leftmost pixel
//   sram_we/addr/data   pixel write, sram_ready accepts it
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last pixel is accepted
//   dbg_state           current FSM state encoding
module text_render_scheduler #(
  parameter int CONSOLE_LINES        = 24,
  parameter int CONSOLE_COLUMNS      = 80,
  parameter int COLOR_NUMBERS_BITS   = 4,
  parameter int HEIGHT_PER_CHARACTER = 20,
  parameter int WIDTH_PER_CHARACTER  = 8,
  parameter int SRAM_ADDR_WIDTH      = 19,
  parameter int BLINK_FRAMES         = 30
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [15:0]                                         cursor_position,
  input  logic [1:0]                                          cursor_mode,
  output logic [$clog2(CONSOLE_LINES*CONSOLE_COLUMNS)-1:0]    cell_addr,
  input  logic [7:0]                                          cell_char,
  input  logic [COLOR_NUMBERS_BITS-1:0]                       cell_fg,
  input  logic [COLOR_NUMBERS_BITS-1:0]                       cell_bg,
  output logic                                                font_req,
  output logic [7:0]                                          font_char,
  output logic [$clog2(HEIGHT_PER_CHARACTER)-1:0]             font_row,
  input  logic                                                font_ack,
  input  logic [WIDTH_PER_CHARACTER-1:0]                      font_bits,
  output logic                                                sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0]                          sram_addr,
  output logic [COLOR_NUMBERS_BITS-1:0]                       sram_data,
  input  logic                                                sram_ready,
  output logic                                                busy,
  output logic                                                frame_done,
  output logic [2:0]                                          dbg_state
);

  localparam int CELL_W  = $clog2(CONSOLE_LINES * CONSOLE_COLUMNS);
  localparam int GROW_W  = $clog2(HEIGHT_PER_CHARACTER);
  localparam int ROW_W   = (CONSOLE_LINES > 1) ? $clog2(CONSOLE_LINES) : 1;
  localparam int COL_W   = (CONSOLE_COLUMNS > 1) ? $clog2(CONSOLE_COLUMNS) : 1;
  localparam int PX_W    = (WIDTH_PER_CHARACTER > 1) ? $clog2(WIDTH_PER_CHARACTER) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CB      = COLOR_NUMBERS_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_FONT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [GROW_W-1:0]        grow_q, grow_d;
  logic [PX_W-1:0]          px_q, px_d;
  logic [CELL_W-1:0]        cell_idx_q, cell_idx_d;
  logic [15:0]              cur_pos_q, cur_pos_d;
  logic [1:0]               cur_mode_q, cur_mode_d;
  logic [7:0]               char_q, char_d;
  logic [CB-1:0]            fg_q, fg_d;
  logic [CB-1:0]            bg_q, bg_d;
  logic [WIDTH_PER_CHARACTER-1:0] bits_q, bits_d;
  logic [BLINK_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                     blink_phase_q, blink_phase_d;

  logic px_last, grow_last, col_last, row_last, cell_last;
  logic cursor_visible, cursor_hit;
  logic [7:0] cur_row, cur_col;
  logic [PX_W-1:0] bit_sel;

  assign px_last   = (px_q == PX_W'(WIDTH_PER_CHARACTER - 1));
  assign grow_last = (grow_q == GROW_W'(HEIGHT_PER_CHARACTER - 1));
  assign col_last  = (col_q == COL_W'(CONSOLE_COLUMNS - 1));
  assign row_last  = (row_q == ROW_W'(CONSOLE_LINES - 1));
  assign cell_last = row_last && col_last;

  assign cur_row = cur_pos_q[15:8];
  assign cur_col = cur_pos_q[7:0];

  // Cursor mode 3 falls through to "not visible" on purpose.
  assign cursor_visible = (cur_mode_q == 2'd2) || ((cur_mode_q == 2'd0) && blink_phase_q);

  // Out-of-range cursor coordinates must never alias onto a real cell,
  // so rows and columns are compared separately at full width.
  assign cursor_hit = cursor_visible
                   && (32'(cur_row) < 32'(CONSOLE_LINES))
                   && (32'(cur_col) < 32'(CONSOLE_COLUMNS))
                   && (32'(cur_row) == 32'(row_q))
                   && (32'(cur_col) == 32'(col_q));

  // Pixel 0 is the leftmost pixel, which is the MSB of the glyph row.
  assign bit_sel = PX_W'(WIDTH_PER_CHARACTER - 1) - px_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_FONT;
      S_FONT:  if (font_ack) state_d = S_WRITE;
      S_WRITE: begin
        if (sram_ready && px_last) begin
          if (!grow_last)     state_d = S_FONT;
          else if (cell_last) state_d = S_DONE;
          else                state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                 (state_q == S_FONT)  || (state_q == S_WRITE);
    frame_done = (state_q == S_DONE);
    font_req   = (state_q == S_FONT);
    sram_we    = (state_q == S_WRITE);
    cell_addr  = cell_idx_q;
    font_char  = char_q;
    font_row   = grow_q;
    sram_data  = bits_q[bit_sel] ? fg_q : bg_q;
    sram_addr  = SRAM_ADDR_WIDTH'(
                   (32'(row_q) * HEIGHT_PER_CHARACTER + 32'(grow_q))
                   * (CONSOLE_COLUMNS * WIDTH_PER_CHARACTER)
                   + 32'(col_q) * WIDTH_PER_CHARACTER + 32'(px_q));
    dbg_state  = state_q;
  end

  // Datapath next-state
  always_comb begin
    row_d         = row_q;
    col_d         = col_q;
    grow_d        = grow_q;
    px_d          = px_q;
    cell_idx_d    = cell_idx_q;
    cur_pos_d     = cur_pos_q;
    cur_mode_d    = cur_mode_q;
    char_d        = char_q;
    fg_d          = fg_q;
    bg_d          = bg_q;
    bits_d        = bits_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_pos_d  = cursor_position;
          cur_mode_d = cursor_mode;
          row_d      = '0;
          col_d      = '0;
          grow_d     = '0;
          px_d       = '0;
          cell_idx_d = '0;
        end
      end
      S_LATCH: begin
        char_d = cell_char;
        if (cursor_hit) begin
          fg_d = cell_bg;
          bg_d = cell_fg;
        end else begin
          fg_d = cell_fg;
          bg_d = cell_bg;
        end
      end
      S_FONT: begin
        if (font_ack) begin
          bits_d = font_bits;
          px_d   = '0;
        end
      end
      S_WRITE: begin
        if (sram_ready) begin
          if (!px_last) begin
            px_d = px_q + 1'b1;
          end else begin
            px_d = '0;
            if (!grow_last) begin
              grow_d = grow_q + 1'b1;
            end else if (!cell_last) begin
              // Counters stay on the last cell when the frame completes.
              grow_d     = '0;
              cell_idx_d = cell_idx_q + 1'b1;
              if (col_last) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end
        end
      end
      S_DONE: begin
        if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q         <= '0;
      col_q         <= '0;
      grow_q        <= '0;
      px_q          <= '0;
      cell_idx_q    <= '0;
      cur_pos_q     <= '0;
      cur_mode_q    <= '0;
      char_q        <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      bits_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      grow_q        <= grow_d;
      px_q          <= px_d;
      cell_idx_q    <= cell_idx_d;
      cur_pos_q     <= cur_pos_d;
      cur_mode_q    <= cur_mode_d;
      char_q        <= char_d;
      fg_q          <= fg_d;
      bg_q          <= bg_d;
      bits_q        <= bits_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

endmodule

// File: tb/tb_text_render_scheduler.sv
// Testbench for text_render_scheduler on a small 2x3 console with a
// two-frame blink period. Expected pixel writes and font requests are
// generated per frame from the rendering rules and queued; monitors pop and
// compare as the DUT transfers.
module tb_text_render_scheduler;

  localparam int L  = 2;
  localparam int C  = 3;
  localparam int CB = 4;
  localparam int H  = 20;
  localparam int W  = 8;
  localparam int AW = 19;
  localparam int BF = 2;
  localparam int EW = AW + CB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [15:0]   cursor_position;
  logic [1:0]    cursor_mode;
  logic [2:0]    cell_addr;
  logic [7:0]    cell_char;
  logic [CB-1:0] cell_fg, cell_bg;
  logic          font_req;
  logic [7:0]    font_char;
  logic [4:0]    font_row;
  logic          font_ack;
  logic [W-1:0]  font_bits;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [CB-1:0] sram_data;
  logic          sram_ready;
  logic          busy, frame_done;
  logic [2:0]    dbg_state;

  text_render_scheduler #(
    .CONSOLE_LINES(L), .CONSOLE_COLUMNS(C), .COLOR_NUMBERS_BITS(CB),
    .HEIGHT_PER_CHARACTER(H), .WIDTH_PER_CHARACTER(W),
    .SRAM_ADDR_WIDTH(AW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cursor_position(cursor_position), .cursor_mode(cursor_mode),
    .cell_addr(cell_addr), .cell_char(cell_char), .cell_fg(cell_fg), .cell_bg(cell_bg),
    .font_req(font_req), .font_char(font_char), .font_row(font_row),
    .font_ack(font_ack), .font_bits(font_bits),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_data(sram_data), .sram_ready(sram_ready),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- environment state ----------------
  logic [7:0]    char_tbl [8];
  logic [CB-1:0] fg_tbl   [8];
  logic [CB-1:0] bg_tbl   [8];

  assign cell_char = char_tbl[cell_addr];
  assign cell_fg   = fg_tbl[cell_addr];
  assign cell_bg   = bg_tbl[cell_addr];

  logic [EW-1:0]   exp_q[$];
  logic [12:0]     fexp_q[$];
  logic [CB-1:0]   wmem [int];

  int n_checks, n_errors;
  int ready_pct, font_dly_max, font_mode;
  logic [7:0] font_const, font_seed;
  int frames_since_rst, wr_count, first_addr;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] glyph(input logic [7:0] c, input logic [4:0] r);
    if (font_mode == 0) return font_const;
    return ((c ^ font_seed) * 8'd13) ^ {r, r[2:0]};
  endfunction

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  // Frame k after reset shows the blinking cursor while (k / BF) is even.
  task automatic push_frame(input logic [15:0] cp, input logic [1:0] cm, input int k);
    bit vis;
    logic [7:0] ch, bits;
    logic [CB-1:0] fg, bg, t;
    int addr;
    vis = (cm == 2'd2) || ((cm == 2'd0) && (((k / BF) % 2) == 0));
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < C; c++) begin
        ch = char_tbl[r*C + c];
        fg = fg_tbl[r*C + c];
        bg = bg_tbl[r*C + c];
        if (vis && int'(cp[15:8]) == r && int'(cp[7:0]) == c) begin
          t = fg; fg = bg; bg = t;
        end
        for (int g = 0; g < H; g++) begin
          fexp_q.push_back({ch, 5'(g)});
          bits = glyph(ch, 5'(g));
          for (int p = 0; p < W; p++) begin
            addr = (r*H + g) * (C*W) + c*W + p;
            exp_q.push_back({AW'(addr), bits[W-1-p] ? fg : bg});
          end
        end
      end
    end
  endtask

  // ---------------- SRAM side: ready driver + write monitor ----------------
  initial begin
    logic prev_stall;
    logic [EW-1:0] prev_w, got, want;
    prev_stall = 1'b0;
    prev_w = '0;
    sram_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        prev_stall = 1'b0;
        sram_ready = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_we_held", 32'(sram_we), 32'd1);
          check("stall_addr_data_held", 32'({sram_addr, sram_data}), 32'(prev_w));
        end
        sram_ready = ($urandom_range(99, 0) < ready_pct);
        if (sram_we && sram_ready) begin
          got = {sram_addr, sram_data};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write actual=%0h expected=none", got);
          end else begin
            want = exp_q.pop_front();
            check("pixel_write", 32'(got), 32'(want));
          end
          if (wr_count == 0) first_addr = int'(sram_addr);
          wmem[int'(sram_addr)] = sram_data;
          wr_count++;
        end
        prev_stall = sram_we && !sram_ready;
        prev_w = {sram_addr, sram_data};
      end
    end
  end

  // ---------------- font side: delayed acknowledge + request monitor ----------------
  initial begin
    int wait_cnt;
    bit waiting;
    logic [7:0] hc;
    logic [4:0] hr;
    logic [12:0] want;
    font_ack = 1'b0;
    font_bits = '0;
    waiting = 1'b0;
    wait_cnt = 0;
    hc = '0;
    hr = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        font_ack = 1'b0;
        waiting = 1'b0;
      end else if (font_ack) begin
        font_ack = 1'b0;
      end else if (font_req) begin
        if (!waiting) begin
          waiting = 1'b1;
          wait_cnt = $urandom_range(font_dly_max, 0);
          hc = font_char;
          hr = font_row;
        end else begin
          check("font_req_held", 32'({font_char, font_row}), 32'({hc, hr}));
        end
        if (wait_cnt == 0) begin
          font_ack = 1'b1;
          font_bits = glyph(font_char, font_row);
          if (fexp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_font_req actual=%0h expected=none", {font_char, font_row});
          end else begin
            want = fexp_q.pop_front();
            check("font_req", 32'({font_char, font_row}), 32'(want));
          end
          waiting = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cells(input bit rnd, input logic [CB-1:0] fg, input logic [CB-1:0] bg);
    for (int i = 0; i < 8; i++) begin
      char_tbl[i] = rnd ? 8'($urandom_range(255, 0)) : 8'(i);
      fg_tbl[i]   = rnd ? CB'($urandom_range(15, 0)) : fg;
      bg_tbl[i]   = rnd ? CB'($urandom_range(15, 0)) : bg;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_font_req"},   32'(font_req), 32'd0);
    check({tag, "_sram_we"},    32'(sram_we), 32'd0);
    check({tag, "_cell_addr"},  32'(cell_addr), 32'd0);
    check({tag, "_font_char"},  32'(font_char), 32'd0);
    check({tag, "_font_row"},   32'(font_row), 32'd0);
    check({tag, "_sram_addr"},  32'(sram_addr), 32'd0);
    check({tag, "_sram_data"},  32'(sram_data), 32'd0);
  endtask

  task automatic issue_start(input logic [15:0] cp, input logic [1:0] cm);
    push_frame(cp, cm, frames_since_rst);
    wmem.delete();
    wr_count = 0;
    first_addr = -1;
    @(negedge clk);
    start = 1'b1;
    cursor_position = cp;
    cursor_mode = cm;
    @(negedge clk);
    start = 1'b0;
    // Cursor inputs move mid-frame; the latched values must win.
    cursor_position = 16'($urandom_range(16'hFFFF, 0));
    cursor_mode = 2'($urandom_range(3, 0));
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] cp, input logic [1:0] cm, input bit poke_start);
    int cyc;
    bit got;
    issue_start(cp, cm);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20000 && !got) begin
      @(negedge clk);
      cyc++;
      start = (poke_start && cyc == 50);
      if (frame_done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout actual=%0d expected=frame_done", cyc);
      report();
    end
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("writes_per_frame", 32'(wr_count), 32'(L*C*H*W));
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("font_queue_drained", 32'(fexp_q.size()), 32'd0);
    @(negedge clk);
    check("frame_done_single_pulse", 32'(frame_done), 32'd0);
    frames_since_rst++;
  endtask

  function automatic int count_cell(input int r, input int c, input logic [CB-1:0] v);
    int n;
    n = 0;
    for (int g = 0; g < H; g++)
      for (int p = 0; p < W; p++)
        if (wmem.exists((r*H + g)*(C*W) + c*W + p) && wmem[(r*H + g)*(C*W) + c*W + p] == v) n++;
    return n;
  endfunction

  function automatic int count_value(input logic [CB-1:0] v);
    int n;
    n = 0;
    foreach (wmem[a]) if (wmem[a] == v) n++;
    return n;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int wr_before;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start = 1'b0;
    cursor_position = '0;
    cursor_mode = '0;
    ready_pct = 100;
    font_dly_max = 0;
    font_mode = 0;
    font_const = 8'hF0;
    font_seed = 8'h00;
    frames_since_rst = 0;
    wr_count = 0;
    first_addr = -1;
    set_cells(1'b0, 4'd1, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Basic frame: glyph F0, fg=1, bg=0, cursor off.
    run_frame(16'h0000, 2'd1, 1'b0);
    check("unique_addresses", 32'(wmem.num()), 32'd960);
    check("first_write_addr", 32'(first_addr), 32'd0);
    for (int p = 0; p < 4; p++) check("first_row_left_fg", 32'(wmem[p]), 32'd1);
    for (int p = 4; p < 8; p++) check("first_row_right_bg", 32'(wmem[p]), 32'd0);
    check("last_addr_written", 32'(wmem.exists(959)), 32'd1);

    // Single leftmost pixel: cell (1,1) glyph row 0 starts at 488.
    font_const = 8'h80;
    set_cells(1'b0, 4'd7, 4'd3);
    run_frame(16'h0000, 2'd3, 1'b0);
    check("cell4_px0_fg", 32'(wmem[488]), 32'd7);
    check("cell4_px1_bg", 32'(wmem[489]), 32'd3);
    check("cell4_px7_bg", 32'(wmem[495]), 32'd3);

    // Persistent cursor on (1,2) swaps that cell; mode 1 does not.
    font_const = 8'hFF;
    set_cells(1'b0, 4'd5, 4'd2);
    run_frame(16'h0102, 2'd2, 1'b0);
    check("cursor_mode2_swapped", 32'(count_cell(1, 2, 4'd2)), 32'd160);
    check("cursor_mode2_other_cell", 32'(count_cell(0, 0, 4'd5)), 32'd160);
    run_frame(16'h0102, 2'd1, 1'b0);
    check("cursor_mode1_plain", 32'(count_cell(1, 2, 4'd5)), 32'd160);

    // Random cells, glyphs, stalls; a stray start mid-frame is ignored.
    ready_pct = 50;
    font_dly_max = 5;
    font_mode = 1;
    font_seed = 8'($urandom_range(255, 0));
    set_cells(1'b1, 4'd0, 4'd0);
    run_frame({8'($urandom_range(1, 0)), 8'($urandom_range(2, 0))}, 2'($urandom_range(3, 0)), 1'b1);

    // Reset in the middle of WRITE.
    set_cells(1'b1, 4'd0, 4'd0);
    issue_start(16'h0000, 2'd2);
    cyc = 0;
    while (cyc < 5000 && !(wr_count >= 100 && sram_we)) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_mid_write", 32'(sram_we), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    fexp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frames_since_rst = 0;
    wr_before = wr_count;
    @(negedge clk);
    check_idle_outputs("midframe_reset");
    repeat (20) @(negedge clk);
    check("no_writes_after_reset", 32'(wr_count), 32'(wr_before));

    // Blinking cursor at (0,1): visible for two frames, hidden for two.
    ready_pct = 50;
    font_dly_max = 3;
    font_mode = 0;
    font_const = 8'hFF;
    set_cells(1'b0, 4'd5, 4'd2);
    for (int f = 0; f < 4; f++) begin
      run_frame(16'h0001, 2'd0, 1'b0);
      if (f == 0) check("post_reset_first_addr", 32'(first_addr), 32'd0);
      check("blink_cursor_pixel", 32'(wmem[8]), (f < 2) ? 32'd2 : 32'd5);
    end

    // Out-of-range cursor row and column never match any cell.
    ready_pct = 100;
    font_dly_max = 0;
    run_frame(16'h0205, 2'd2, 1'b0);
    check("cursor_row_out_of_range", 32'(count_value(4'd2)), 32'd0);
    run_frame(16'h0003, 2'd2, 1'b0);
    check("cursor_col_out_of_range", 32'(count_value(4'd2)), 32'd0);

    repeat (5) @(negedge clk);
    report();
  end

endmodule
